// File: rtl/table_buffer_param.sv
// ROWS x COLS element table, filled by parallel load or row-serial stream, with a registered indexed read port.
// Optional sliding-window row shift enabled by defining TABLE_BUFFER_ROW_SHIFT_EN.
module table_buffer_param #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 4,
    parameter int COLS   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          ld,
    input  logic [ROWS*COLS*DATA_W-1:0]   in,
    input  logic                          row_valid,
    output logic                          row_ready,
    input  logic [COLS*DATA_W-1:0]        row_data,
    input  logic                          rd_en,
    input  logic [$clog2(ROWS)-1:0]       row,
    input  logic [$clog2(COLS)-1:0]       col,
    output logic [DATA_W-1:0]             out,
    output logic                          out_valid,
    output logic                          full,
    output logic [$clog2(ROWS+1)-1:0]     rows_loaded
);

    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int CNT_W = $clog2(ROWS+1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     tbl_q [ROWS][COLS];
    logic [DATA_W-1:0]     tbl_d [ROWS][COLS];
    logic [RW-1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  row_accept;
    logic [DATA_W-1:0]     rd_val;

`ifdef TABLE_BUFFER_ROW_SHIFT_EN
    assign row_ready = !ld && !clr;
`else
    assign row_ready = (state_q != FULL) && !ld && !clr;
`endif

    assign row_accept  = row_valid && row_ready;
    assign full        = (state_q == FULL);
    assign rows_loaded = cnt_q;
    assign out         = out_q;
    assign out_valid   = out_valid_q;

    // Writer priority is clr, then ld, then a handshaken streamed row.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        tbl_d   = tbl_q;
        if (clr) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    tbl_d[r][c] = '0;
            cnt_d   = '0;
            ptr_d   = '0;
            state_d = EMPTY;
        end else if (ld) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    tbl_d[r][c] = in[(ROWS*COLS-1-(r*COLS+c))*DATA_W +: DATA_W];
            cnt_d   = CNT_W'(ROWS);
            ptr_d   = '0;
            state_d = FULL;
        end else if (row_accept) begin
`ifdef TABLE_BUFFER_ROW_SHIFT_EN
            if (state_q == FULL) begin
                for (int r = 0; r < ROWS-1; r++)
                    tbl_d[r] = tbl_q[r+1];
                for (int c = 0; c < COLS; c++)
                    tbl_d[ROWS-1][c] = row_data[(COLS-1-c)*DATA_W +: DATA_W];
            end else begin
`else
            begin
`endif
                for (int r = 0; r < ROWS; r++)
                    if (RW'(r) == ptr_q)
                        for (int c = 0; c < COLS; c++)
                            tbl_d[r][c] = row_data[(COLS-1-c)*DATA_W +: DATA_W];
                if (cnt_q == CNT_W'(ROWS-1)) begin
                    cnt_d   = CNT_W'(ROWS);
                    ptr_d   = '0;
                    state_d = FULL;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    ptr_d   = ptr_q + RW'(1);
                    state_d = FILLING;
                end
            end
        end
    end

    // Read uses the pre-write table, so same-edge writes return the old value; unmatched indices give 0.
    always_comb begin
        rd_val = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if ((RW'(r) == row) && (CW'(c) == col))
                    rd_val = tbl_q[r][c];
        out_d       = rd_en ? rd_val : out_q;
        out_valid_d = rd_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            ptr_q       <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    tbl_q[r][c] <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            tbl_q       <= tbl_d;
        end
    end

endmodule

// File: doc/table_buffer_param.md
Name: table_buffer_param

Overview:
- Parametrised successor to the fixed 4x4 byte table buffer in the convolution datapath.
- Holds a ROWS x COLS table of DATA_W-bit elements (kernel or input tile).
- Two ways to fill the table:
  - a whole-table parallel load;
  - a row-serial valid/ready stream.
- Read port: indexed, one read per cycle, registered output. Tracks fill state so the convolution controller can wait on `full`.

Parameters:
- DATA_W, 8, element width in bits.
- ROWS, 4, table rows; must be >= 2.
- COLS, 4, table columns; must be >= 2.
- Derived localparams:
  - RW = $clog2(ROWS)
  - CW = $clog2(COLS)
  - CNT_W = $clog2(ROWS+1)

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- clr  in  1  synchronous clear of table, counters and state.
- ld  in  1  parallel load of the whole table from `in`.
- in  in  ROWS*COLS*DATA_W  table image, row-major; element [0][0] in the MSBs, [ROWS-1][COLS-1] in the LSBs.
- row_valid  in  1  streamed row offered.
- row_ready  out  1  buffer can accept a streamed row.
- row_data  in  COLS*DATA_W  one row; column 0 in the MSBs.
- rd_en  in  1  read request.
- row  in  RW  read row index.
- col  in  CW  read column index.
- out  out  DATA_W  registered read data.
- out_valid  out  1  one-cycle pulse, `out` updated.
- full  out  1  table completely loaded.
- rows_loaded  out  CNT_W  number of valid rows, 0..ROWS.

Behaviour:
- Reset (async, rst=1):
  - all table elements, out, out_valid, rows_loaded and write pointer = 0;
  - state = EMPTY, full = 0.
  - Reset mid-fill or mid-read discards everything; no partial state survives.
- States:
  - EMPTY: rows_loaded = 0.
  - FILLING: 0 < rows_loaded < ROWS.
  - FULL: rows_loaded = ROWS, full = 1.
- Per-cycle priority of table writers: clr > ld > streamed row.
- clr:
  - zeroes the table, rows_loaded and write pointer; state = EMPTY.
  - Does not affect a read issued in the same cycle: that read returns the pre-clear value.
- ld:
  - writes the entire table from `in`; rows_loaded = ROWS; write pointer = 0; state = FULL.
  - Legal from any state.
- Streamed row:
  - Handshake completes when row_valid && row_ready on the same edge.
  - row_data is written to row[write pointer]; the pointer increments and rows_loaded increments.
  - When rows_loaded reaches ROWS: state = FULL and the pointer wraps to 0.
- row_ready (combinational) = (state != FULL) && !ld && !clr, so a row presented in a ld/clr cycle is never handshaken and is not lost silently.
- Read:
  - rd_en samples row/col at the edge.
  - out = table[row][col] on the next edge (1-cycle latency); out_valid = 1 for exactly that cycle.
  - out holds its value when rd_en = 0.
- Read/write collision: a read of an element written on the same edge returns the old value (read-before-write).
- Out-of-range index (row >= ROWS or col >= COLS, only possible for non-power-of-2 dims): out = 0 and out_valid still pulses.
- Reads are allowed in every state; unloaded rows read as 0.

Optional Feature:
- Macro: TABLE_BUFFER_ROW_SHIFT_EN.
- Defined (sliding-window mode for a vertically scanning convolution):
  - In FULL, row_ready stays high (still gated by !ld && !clr).
  - An accepted row shifts the table up: row 0 is discarded, row i takes row i+1, and row ROWS-1 takes row_data.
  - full stays 1 and rows_loaded stays ROWS.
  - A read on the same edge returns the pre-shift value.
- Undefined: row_ready = 0 in FULL; only clr or ld changes table contents.

Test Plan:
- Reset then read: rst pulse; rd_en with row=2, col=3 -> next cycle out=0x00, out_valid=1; full=0; rows_loaded=0.
- Parallel load: ld=1 with in=128'h000102...0F (4x4x8) -> full=1, rows_loaded=4; reading [1][2] gives 0x06; reading [3][3] gives 0x0F one cycle after rd_en.
- Streamed fill with stalls: rows 0xA0A1A2A3, 0xB0B1B2B3, 0xC0C1C2C3, 0xD0D1D2D3 sent with row_valid gaps:
  - rows_loaded steps 1, 2, 3, 4; full rises after the 4th handshake;
  - then row_ready = 0;
  - reading [2][1] gives 0xC1.
- Collisions: ld and row_valid asserted in the same cycle -> row_ready=0 and the table equals `in`. clr and rd_en on [0][0]=0x11 in the same cycle -> out=0x11, and the table reads 0 afterwards.
- Async reset mid-fill: assert rst between edges after 2 streamed rows -> rows_loaded=0, full=0 and out=0 immediately; next streamed row lands in row 0.
- With TABLE_BUFFER_ROW_SHIFT_EN: after the streamed fill above, push 0xE0E1E2E3 -> [0][0]=0xB0, [3][3]=0xE3, full stays 1. Without the macro, the same push is not accepted (row_ready=0).
